hwpe_stream_realign_ctrl_gen: RTL and testbench

- Upstream control/address stage for hwpe_stream_source_realign.
- Walks a 2D region of lines: base address, line stride in bytes, line length in words, number of lines.
- Per beat, issues word-aligned fetch addresses with a valid/ready handshake.
- Per line, produces the realign control fields and byte strobe that the source realigner consumes. Unaligned lines are extended by one word, with first/last strobes derived from the byte offset.

---
 rtl/hwpe_stream_realign_ctrl_gen_if.sv | 32 +++
 rtl/hwpe_stream_realign_ctrl_gen.sv | 187 ++++++++++++++++++
 tb/tb_hwpe_stream_realign_ctrl_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_realign_ctrl_gen_if.sv
// Fetch-request and realign-control bundle between the control generator
// (master) and the memory/realigner side (slave).
interface hwpe_stream_realign_ctrl_gen_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_valid;
  logic                  req_ready;
  logic                  ctrl_enable;
  logic                  ctrl_realign;
  logic                  ctrl_first;
  logic                  ctrl_last;
  logic                  ctrl_strb_valid;
  logic [LEN_WIDTH-1:0]  ctrl_line_length;
  logic [NB-1:0]         strb;

  modport master (
    output req_addr, req_valid, ctrl_enable, ctrl_realign, ctrl_first,
           ctrl_last, ctrl_strb_valid, ctrl_line_length, strb,
    input  req_ready
  );

  modport slave (
    input  req_addr, req_valid, ctrl_enable, ctrl_realign, ctrl_first,
           ctrl_last, ctrl_strb_valid, ctrl_line_length, strb,
    output req_ready
  );
endinterface

// File: rtl/hwpe_stream_realign_ctrl_gen.sv
// 2D line walker feeding hwpe_stream_source_realign: issues word-aligned fetch
// addresses and per-beat realign control, extending unaligned lines by one word.
module hwpe_stream_realign_ctrl_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] line_stride_i,
  input  logic [LEN_WIDTH-1:0]  line_length_i,
  input  logic [LEN_WIDTH-1:0]  nb_lines_i,
  input  logic                  stall_i,
  hwpe_stream_realign_ctrl_gen_if.master req,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, LINE_START, FETCH, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] line_addr_reg, fetch_addr_reg, stride_reg;
  logic [LEN_WIDTH-1:0]  len_reg, nb_lines_reg, line_cnt_reg, beat_cnt_reg, beats_reg;
  logic                  realign_reg;
  logic [NB-1:0]         first_strb_reg, last_strb_reg;

  logic [OW-1:0]         off;
  logic                  realign_calc;
  logic [LEN_WIDTH-1:0]  beats_calc;
  logic [NB-1:0]         first_strb_calc, last_strb_calc;
  logic                  cfg_empty, handshake, beat_last, line_final;

  logic [ADDR_WIDTH-1:0] req_addr_next;
  logic                  req_valid_next, enable_next, realign_next;
  logic                  first_next, last_next, strb_valid_next;
  logic [LEN_WIDTH-1:0]  line_length_next;
  logic [NB-1:0]         strb_next;

  assign off          = line_addr_reg[OW-1:0];
  assign realign_calc = (off != '0);
  assign beats_calc   = len_reg + LEN_WIDTH'(realign_calc);

  // First beat keeps bytes at or above the offset, the extension beat the rest.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_strb
      assign first_strb_calc[gi] = (OW'(gi) >= off);
      assign last_strb_calc[gi]  = ~realign_calc | (OW'(gi) < off);
    end
  endgenerate

  assign cfg_empty  = (nb_lines_i == '0) | (line_length_i == '0);
  assign handshake  = (state_reg == FETCH) & req.req_ready;
  assign beat_last  = (beat_cnt_reg == beats_reg - LEN_WIDTH'(1));
  assign line_final = (line_cnt_reg == nb_lines_reg - LEN_WIDTH'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      state_reg <= IDLE;
    else if (clear_i) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (start_i) state_next = cfg_empty ? DONE : LINE_START;
      LINE_START: if (!stall_i) state_next = FETCH;
      FETCH:      if (handshake && beat_last) state_next = line_final ? DONE : LINE_START;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_addr_reg  <= '0;
      fetch_addr_reg <= '0;
      stride_reg     <= '0;
      len_reg        <= '0;
      nb_lines_reg   <= '0;
      line_cnt_reg   <= '0;
      beat_cnt_reg   <= '0;
      beats_reg      <= '0;
      realign_reg    <= 1'b0;
      first_strb_reg <= '0;
      last_strb_reg  <= '0;
    end else if (clear_i) begin
      line_addr_reg  <= '0;
      fetch_addr_reg <= '0;
      stride_reg     <= '0;
      len_reg        <= '0;
      nb_lines_reg   <= '0;
      line_cnt_reg   <= '0;
      beat_cnt_reg   <= '0;
      beats_reg      <= '0;
      realign_reg    <= 1'b0;
      first_strb_reg <= '0;
      last_strb_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            line_addr_reg <= base_addr_i;
            stride_reg    <= line_stride_i;
            len_reg       <= line_length_i;
            nb_lines_reg  <= nb_lines_i;
            line_cnt_reg  <= '0;
            beat_cnt_reg  <= '0;
          end
        end
        LINE_START: begin
          if (!stall_i) begin
            realign_reg    <= realign_calc;
            beats_reg      <= beats_calc;
            first_strb_reg <= first_strb_calc;
            last_strb_reg  <= last_strb_calc;
            fetch_addr_reg <= {line_addr_reg[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            beat_cnt_reg   <= '0;
          end
        end
        FETCH: begin
          if (handshake) begin
            fetch_addr_reg <= fetch_addr_reg + ADDR_WIDTH'(NB);
            if (beat_last) begin
              beat_cnt_reg  <= '0;
              line_addr_reg <= line_addr_reg + stride_reg;
              line_cnt_reg  <= line_cnt_reg + LEN_WIDTH'(1);
            end else begin
              beat_cnt_reg <= beat_cnt_reg + LEN_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure functions of registered state, so they hold under backpressure.
  always_comb begin
    req_addr_next    = '0;
    req_valid_next   = 1'b0;
    enable_next      = 1'b0;
    realign_next     = 1'b0;
    first_next       = 1'b0;
    last_next        = 1'b0;
    strb_valid_next  = 1'b0;
    line_length_next = '0;
    strb_next        = '0;
    if (state_reg == FETCH) begin
      req_addr_next    = fetch_addr_reg;
      req_valid_next   = 1'b1;
      enable_next      = 1'b1;
      realign_next     = realign_reg;
      first_next       = (beat_cnt_reg == '0);
      last_next        = beat_last;
      strb_valid_next  = first_next | last_next;
      line_length_next = beats_reg;
      strb_next        = first_next ? first_strb_reg :
                         last_next  ? last_strb_reg  : '1;
    end
  end

  assign req.req_addr         = req_addr_next;
  assign req.req_valid        = req_valid_next;
  assign req.ctrl_enable      = enable_next;
  assign req.ctrl_realign     = realign_next;
  assign req.ctrl_first       = first_next;
  assign req.ctrl_last        = last_next;
  assign req.ctrl_strb_valid  = strb_valid_next;
  assign req.ctrl_line_length = line_length_next;
  assign req.strb             = strb_next;
  assign busy_o               = (state_reg != IDLE);
  assign done_o               = (state_reg == DONE);

`ifndef SYNTHESIS
  // The one-word extension must not overflow the beat count.
  a_beats_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == LINE_START && !stall_i && realign_calc) |-> (len_reg != '1));
`endif

endmodule

// File: tb/tb_hwpe_stream_realign_ctrl_gen.sv
// Directed bench for hwpe_stream_realign_ctrl_gen with 32-bit words.
module tb_hwpe_stream_realign_ctrl_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] line_stride_i = '0;
  logic [15:0] line_length_i = '0;
  logic [15:0] nb_lines_i = '0;
  logic        stall_i = 1'b0;
  logic        busy_o, done_o;

  int checks = 0;
  int failures = 0;

  hwpe_stream_realign_ctrl_gen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) req_if ();

  hwpe_stream_realign_ctrl_gen #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .line_stride_i(line_stride_i),
    .line_length_i(line_length_i), .nb_lines_i(nb_lines_i), .stall_i(stall_i),
    .req(req_if), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Recorded per-handshake observations
  logic [31:0] a_addr [0:31];
  logic        a_first [0:31];
  logic        a_last [0:31];
  logic        a_sv [0:31];
  logic        a_re [0:31];
  logic [15:0] a_len [0:31];
  logic [3:0]  a_strb [0:31];
  int          hs_cyc [0:31];
  logic        v_hist [0:127];
  logic        b_hist [0:127];
  int nbeats, done_cnt, done_cyc, unstable, valid_cnt;
  bit finished;

  task automatic start_job(input logic [31:0] base, input logic [31:0] stride,
                           input logic [15:0] len, input logic [15:0] lines);
    base_addr_i = base; line_stride_i = stride; line_length_i = len; nb_lines_i = lines;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Cycle 0 is the first cycle after start_i was sampled.
  task automatic collect(input int budget, input bit rnd, input int stall_cycles, input int clear_at);
    bit held = 1'b0;
    logic [31:0] h_addr = '0;
    logic [3:0]  h_strb = '0;
    logic [5:0]  h_ctrl = '0;
    logic [15:0] h_len = '0;
    logic [5:0]  cur_ctrl;
    nbeats = 0; done_cnt = 0; done_cyc = -1; unstable = 0; valid_cnt = 0; finished = 0;
    for (int c = 0; c < budget; c++) begin
      req_if.req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_i = (c < stall_cycles);
      clear_i = (c == clear_at);
      #1;
      cur_ctrl = {req_if.ctrl_enable, req_if.ctrl_realign, req_if.ctrl_first,
                  req_if.ctrl_last, req_if.ctrl_strb_valid, req_if.req_valid};
      v_hist[c] = req_if.req_valid;
      b_hist[c] = busy_o;
      if (held && (req_if.req_addr !== h_addr || req_if.strb !== h_strb ||
                   cur_ctrl !== h_ctrl || req_if.ctrl_line_length !== h_len))
        unstable++;
      if (done_cyc >= 0 && c > done_cyc) begin
        if (done_o) done_cnt++;
        finished = 1;
        break;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = c;
      end
      if (req_if.req_valid) valid_cnt++;
      if (req_if.req_valid && req_if.req_ready && !clear_i && nbeats < 32) begin
        a_addr[nbeats]  = req_if.req_addr;
        a_first[nbeats] = req_if.ctrl_first;
        a_last[nbeats]  = req_if.ctrl_last;
        a_sv[nbeats]    = req_if.ctrl_strb_valid;
        a_re[nbeats]    = req_if.ctrl_realign;
        a_len[nbeats]   = req_if.ctrl_line_length;
        a_strb[nbeats]  = req_if.strb;
        hs_cyc[nbeats]  = c;
        $display("beat %0d cyc=%0d addr=%h first=%b last=%b strb=%h len=%0d realign=%b",
                 nbeats, c, req_if.req_addr, req_if.ctrl_first, req_if.ctrl_last,
                 req_if.strb, req_if.ctrl_line_length, req_if.ctrl_realign);
        nbeats++;
      end
      held   = req_if.req_valid && !req_if.req_ready && !clear_i;
      h_addr = req_if.req_addr;
      h_strb = req_if.strb;
      h_ctrl = cur_ctrl;
      h_len  = req_if.ctrl_line_length;
      @(posedge clk_i); #1;
    end
    stall_i = 1'b0; clear_i = 1'b0; req_if.req_ready = 1'b1;
  endtask

  task automatic test_reset();
    req_if.req_ready = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (req_if.req_valid !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failures++; $display("FAIL reset_flags valid=%b busy=%b done=%b want 000", req_if.req_valid, busy_o, done_o); end
    checks++; if (req_if.req_addr !== 32'h0 || req_if.strb !== 4'h0 || req_if.ctrl_line_length !== 16'h0) begin
      failures++; $display("FAIL reset_data addr=%h strb=%h len=%0d want 0", req_if.req_addr, req_if.strb, req_if.ctrl_line_length); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (busy_o !== 1'b0 || req_if.ctrl_enable !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle busy=%b enable=%b want 00", busy_o, req_if.ctrl_enable); end
    $display("reset done");
  endtask

  task automatic test_aligned();
    logic [31:0] exp_a [8] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h140, 32'h144, 32'h148, 32'h14C};
    start_job(32'h100, 32'h40, 16'd4, 16'd2);
    collect(60, 1'b0, 0, -1);
    checks++; if (nbeats !== 8) begin failures++; $display("FAIL aligned_beats got=%0d want=8", nbeats); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (a_addr[i] !== exp_a[i] || a_re[i] !== 1'b0 || a_len[i] !== 16'd4) begin
        failures++; $display("FAIL aligned_beat%0d addr=%h re=%b len=%0d want addr=%h re=0 len=4", i, a_addr[i], a_re[i], a_len[i], exp_a[i]); end
    end
    checks++; if (a_strb[0] !== 4'hF || a_strb[3] !== 4'hF || a_first[0] !== 1'b1 || a_last[3] !== 1'b1 || a_first[1] !== 1'b0) begin
      failures++; $display("FAIL aligned_edges strb0=%h strb3=%h f0=%b l3=%b f1=%b want F F 1 1 0", a_strb[0], a_strb[3], a_first[0], a_last[3], a_first[1]); end
    checks++; if (hs_cyc[0] !== 1 || hs_cyc[3] !== 4 || hs_cyc[4] !== 6) begin
      failures++; $display("FAIL aligned_timing hs0=%0d hs3=%0d hs4=%0d want 1 4 6", hs_cyc[0], hs_cyc[3], hs_cyc[4]); end
    checks++; if (!finished || done_cyc !== 10 || done_cnt !== 1) begin
      failures++; $display("FAIL aligned_done fin=%0d cyc=%0d cnt=%0d want 1 10 1", finished, done_cyc, done_cnt); end
  endtask

  task automatic test_unaligned();
    logic [3:0] exp_s [4] = '{4'h8, 4'hF, 4'hF, 4'h7};
    logic       exp_sv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    start_job(32'h103, 32'h40, 16'd3, 16'd1);
    collect(40, 1'b0, 0, -1);
    checks++; if (nbeats !== 4) begin failures++; $display("FAIL unaligned_beats got=%0d want=4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_addr[i] !== 32'h100 + 32'(4 * i) || a_strb[i] !== exp_s[i] || a_sv[i] !== exp_sv[i] ||
                    a_re[i] !== 1'b1 || a_len[i] !== 16'd4 || a_first[i] !== (i == 0) || a_last[i] !== (i == 3)) begin
        failures++; $display("FAIL unaligned_beat%0d addr=%h strb=%h sv=%b re=%b len=%0d f=%b l=%b want addr=%h strb=%h sv=%b re=1 len=4",
                             i, a_addr[i], a_strb[i], a_sv[i], a_re[i], a_len[i], a_first[i], a_last[i], 32'h100 + 32'(4 * i), exp_s[i], exp_sv[i]); end
    end
    checks++; if (!finished || done_cnt !== 1) begin failures++; $display("FAIL unaligned_done fin=%0d cnt=%0d want 1 1", finished, done_cnt); end
  endtask

  task automatic test_offset2();
    start_job(32'h202, 32'h40, 16'd1, 16'd1);
    collect(40, 1'b0, 0, -1);
    checks++; if (nbeats !== 2 || a_addr[0] !== 32'h200 || a_addr[1] !== 32'h204) begin
      failures++; $display("FAIL off2_addr n=%0d a0=%h a1=%h want 2 200 204", nbeats, a_addr[0], a_addr[1]); end
    checks++; if (a_strb[0] !== 4'hC || a_strb[1] !== 4'h3 || a_sv[0] !== 1'b1 || a_sv[1] !== 1'b1) begin
      failures++; $display("FAIL off2_strb s0=%h s1=%h sv=%b%b want C 3 11", a_strb[0], a_strb[1], a_sv[0], a_sv[1]); end
    start_job(32'h200, 32'h40, 16'd1, 16'd1);
    collect(40, 1'b0, 0, -1);
    checks++; if (nbeats !== 1 || a_addr[0] !== 32'h200 || a_first[0] !== 1'b1 || a_last[0] !== 1'b1 ||
                  a_strb[0] !== 4'hF || a_len[0] !== 16'd1 || a_re[0] !== 1'b0) begin
      failures++; $display("FAIL single_beat n=%0d addr=%h f=%b l=%b strb=%h len=%0d re=%b want 1 200 1 1 F 1 0",
                           nbeats, a_addr[0], a_first[0], a_last[0], a_strb[0], a_len[0], a_re[0]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a [8] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h140, 32'h144, 32'h148, 32'h14C};
    start_job(32'h103, 32'h40, 16'd3, 16'd2);
    collect(100, 1'b1, 0, -1);
    checks++; if (nbeats !== 8) begin failures++; $display("FAIL bp_beats got=%0d want=8", nbeats); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable changes=%0d want=0", unstable); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (a_addr[i] !== exp_a[i]) begin
        failures++; $display("FAIL bp_addr%0d got=%h want=%h", i, a_addr[i], exp_a[i]); end
    end
    checks++; if (a_strb[4] !== 4'h8 || a_strb[7] !== 4'h7) begin
      failures++; $display("FAIL bp_line1_strb s4=%h s7=%h want 8 7", a_strb[4], a_strb[7]); end
    checks++; if (!finished || done_cnt !== 1) begin failures++; $display("FAIL bp_done fin=%0d cnt=%0d want 1 1", finished, done_cnt); end
  endtask

  task automatic test_stall();
    int early = 0;
    start_job(32'h300, 32'h40, 16'd2, 16'd1);
    collect(40, 1'b0, 5, -1);
    for (int c = 0; c < 6; c++) if (v_hist[c] !== 1'b0) early++;
    checks++; if (early !== 0) begin failures++; $display("FAIL stall_no_req valid_cycles=%0d want=0", early); end
    checks++; if (nbeats !== 2 || hs_cyc[0] !== 6 || a_addr[0] !== 32'h300) begin
      failures++; $display("FAIL stall_release n=%0d hs0=%0d a0=%h want 2 6 300", nbeats, hs_cyc[0], a_addr[0]); end
  endtask

  task automatic test_clear();
    start_job(32'h100, 32'h40, 16'd4, 16'd1);
    collect(12, 1'b0, 0, 3);
    checks++; if (nbeats !== 2) begin failures++; $display("FAIL clear_beats got=%0d want=2", nbeats); end
    checks++; if (v_hist[4] !== 1'b0 || b_hist[4] !== 1'b0) begin
      failures++; $display("FAIL clear_idle valid=%b busy=%b want 00", v_hist[4], b_hist[4]); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL clear_no_done cnt=%0d want=0", done_cnt); end
  endtask

  task automatic test_empty();
    start_job(32'h100, 32'h40, 16'd4, 16'd0);
    collect(20, 1'b0, 0, -1);
    checks++; if (done_cyc !== 0 || done_cnt !== 1 || valid_cnt !== 0) begin
      failures++; $display("FAIL empty_lines cyc=%0d cnt=%0d valid=%0d want 0 1 0", done_cyc, done_cnt, valid_cnt); end
    start_job(32'h100, 32'h40, 16'd0, 16'd3);
    collect(20, 1'b0, 0, -1);
    checks++; if (done_cyc !== 0 || done_cnt !== 1 || valid_cnt !== 0) begin
      failures++; $display("FAIL empty_len cyc=%0d cnt=%0d valid=%0d want 0 1 0", done_cyc, done_cnt, valid_cnt); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL empty_idle busy=%b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_offset2();
    test_backpressure();
    test_stall();
    test_clear();
    test_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
